// File: rtl/icache_miss_req_buffer.sv
`timescale 1ns/1ps
// icache_miss_req_buffer
// Sits between the core's I$ miss pulses (no backpressure) and the adapter's
// valid/ready miss port. It queues line addresses, merges duplicate lines,
// caps the number of refills in flight, registers the refill return and
// flags lost responses and dropped misses.
module icache_miss_req_buffer #(
  parameter int ADDR_W     = 40,
  parameter int LINE_BYTES = 64,
  parameter int DATA_W     = 512,
  parameter int DEPTH      = 4,
  parameter int MAX_OUT    = 2,
  parameter int TMO_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_paddr_i,
  output logic              miss_valid_o,
  input  logic              miss_ready_i,
  output logic [ADDR_W-1:0] miss_paddr_o,
  input  logic              resp_valid_i,
  input  logic [DATA_W-1:0] resp_data_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [2:0]        pending_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              timeout_o,
  input  logic              clr_err_i
);

  localparam int OFS   = $clog2(LINE_BYTES);
  localparam int LIN_W = ADDR_W - OFS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_PRE = TMO_MAX - TMO_W'(1);

  // Request FIFO storage and pointers (extra wrap bit distinguishes full/empty)
  logic [LIN_W-1:0] r_fifo [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  // Refill tracking
  logic [2:0]       r_pending;
  logic [LIN_W-1:0] r_last_lin;
  logic [TMO_W-1:0] r_tmo;

  // Sticky error flags and retimed response
  logic             r_overflow;
  logic             r_timeout;
  logic             r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  logic [LIN_W-1:0] w_lin;
  logic [PTR_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_miss_valid;
  logic             w_hs;
  logic             w_resp_dec;
  logic [DEPTH-1:0] w_hit;
  logic             w_coal;
  logic             w_push;
  logic             w_ovf_set;
  logic             w_tmo_run;
  logic             w_tmo_set;
  logic             w_unused;

  // Only the line part of the miss address matters; the byte offset is dropped.
  assign w_lin    = req_paddr_i[ADDR_W-1:OFS];
  assign w_unused = &{1'b0, req_paddr_i[OFS-1:0]};

  assign w_count = r_tail - r_head;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PTR_W'(DEPTH));

  // Issue only while the adapter still has a refill slot free. Because
  // pending only grows on a handshake, valid cannot fall without one.
  assign w_miss_valid = !w_empty && (r_pending < 3'(MAX_OUT));
  assign w_hs         = w_miss_valid && miss_ready_i;

  // An unmatched response is forwarded but never drives pending negative.
  assign w_resp_dec = resp_valid_i && (r_pending != 3'd0);

  // Per-slot duplicate detection: a slot is live when its distance from the
  // head is below the current occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IDX_W-1:0] w_ofs;
    assign w_ofs    = IDX_W'(g) - r_head[IDX_W-1:0];
    assign w_hit[g] = ({1'b0, w_ofs} < w_count) && (r_fifo[g] == w_lin);
  end

  // A miss is merged if the line is already queued or is the line just sent
  // out while refills are still outstanding.
  assign w_coal = (|w_hit) || ((r_pending != 3'd0) && (w_lin == r_last_lin));

  // The full check uses the registered occupancy; a pop this cycle does not
  // make room for a miss arriving in the same cycle.
  assign w_push    = req_valid_i && !w_coal && !w_full;
  assign w_ovf_set = req_valid_i && !w_coal && w_full;

  assign w_tmo_run = (r_pending != 3'd0) && !resp_valid_i;
  assign w_tmo_set = w_tmo_run && (r_tmo == TMO_PRE);

  // FIFO write at the tail and pointer advance on push/handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_tail[IDX_W-1:0]] <= w_lin;
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_hs) begin
        r_head <= r_head + PTR_W'(1);
      end
    end
  end

  // In-flight refill count and the line of the most recent handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending  <= 3'd0;
      r_last_lin <= '0;
    end else begin
      r_pending <= r_pending + {2'b00, w_hs} - {2'b00, w_resp_dec};
      if (w_hs) begin
        r_last_lin <= r_fifo[r_head[IDX_W-1:0]];
      end
    end
  end

  // Lost-response watchdog: counts idle cycles while refills are in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo <= '0;
    end else if (!w_tmo_run) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  // Sticky error flags; a set event beats a clear in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (clr_err_i) r_overflow <= 1'b0;
      if (w_tmo_set)      r_timeout  <= 1'b1;
      else if (clr_err_i) r_timeout  <= 1'b0;
    end
  end

  // One-cycle retime of the refill return; data holds between responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= resp_valid_i;
      if (resp_valid_i) begin
        r_resp_data <= resp_data_i;
      end
    end
  end

  assign miss_valid_o = w_miss_valid;
  assign miss_paddr_o = {r_fifo[r_head[IDX_W-1:0]], {OFS{1'b0}}};
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign pending_o    = r_pending;
  assign busy_o       = !w_empty || (r_pending != 3'd0);
  assign overflow_o   = r_overflow;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_icache_miss_req_buffer.sv
`timescale 1ns/1ps
// Bench for icache_miss_req_buffer: table-driven vectors, directed corner
// sequences and random traffic, all compared against a queue-based model.
module tb_icache_miss_req_buffer;

  localparam int ADDR_W     = 40;
  localparam int LINE_BYTES = 64;
  localparam int OFS        = 6;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 4;
  localparam int MAX_OUT    = 2;
  localparam int TMO_W      = 4;
  localparam int LIN_W      = ADDR_W - OFS;
  localparam int TMO_MAX    = (1 << TMO_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid_i = 1'b0;
  logic [ADDR_W-1:0] req_paddr_i = '0;
  logic              miss_valid_o;
  logic              miss_ready_i = 1'b0;
  logic [ADDR_W-1:0] miss_paddr_o;
  logic              resp_valid_i = 1'b0;
  logic [DATA_W-1:0] resp_data_i = '0;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_data_o;
  logic [2:0]        pending_o;
  logic              busy_o;
  logic              overflow_o;
  logic              timeout_o;
  logic              clr_err_i = 1'b0;

  icache_miss_req_buffer #(
    .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .DATA_W(DATA_W),
    .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .TMO_W(TMO_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_paddr_i(req_paddr_i),
    .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i),
    .miss_paddr_o(miss_paddr_o),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .pending_o(pending_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o),
    .clr_err_i(clr_err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [LIN_W-1:0]  m_q[$];
  int                m_pend;
  logic [LIN_W-1:0]  m_last;
  int                m_tmo;
  bit                m_ovf, m_to, m_rv;
  logic [DATA_W-1:0] m_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = 0;
    m_last = '0;
    m_tmo  = 0;
    m_ovf  = 0;
    m_to   = 0;
    m_rv   = 0;
    m_rd   = '0;
  endtask

  // Advance the model by one clock using the inputs presented at that edge
  task automatic model_step();
    logic [LIN_W-1:0] lin;
    bit coal, mv, hs, oset, tset;
    int pre;
    lin  = req_paddr_i[ADDR_W-1:OFS];
    coal = 0;
    foreach (m_q[i]) if (m_q[i] == lin) coal = 1;
    if (m_pend != 0 && lin == m_last) coal = 1;
    mv   = (m_q.size() != 0) && (m_pend < MAX_OUT);
    hs   = mv && miss_ready_i;
    pre  = m_q.size();
    oset = 0;
    tset = 0;
    if (hs) m_last = m_q.pop_front();
    if (req_valid_i && !coal) begin
      if (pre < DEPTH) m_q.push_back(lin);
      else oset = 1;
    end
    if (m_pend == 0 || resp_valid_i) m_tmo = 0;
    else if (m_tmo < TMO_MAX) begin
      m_tmo++;
      if (m_tmo == TMO_MAX) tset = 1;
    end
    m_pend = m_pend + (hs ? 1 : 0) - ((resp_valid_i && m_pend != 0) ? 1 : 0);
    if (oset) m_ovf = 1; else if (clr_err_i) m_ovf = 0;
    if (tset) m_to = 1;  else if (clr_err_i) m_to = 0;
    m_rv = resp_valid_i;
    if (resp_valid_i) m_rd = resp_data_i;
  endtask

  task automatic model_check();
    chk("miss_valid", miss_valid_o, (m_q.size() != 0) && (m_pend < MAX_OUT));
    if (m_q.size() != 0) chk("miss_paddr", miss_paddr_o, {m_q[0], {OFS{1'b0}}});
    chk("pending", pending_o, m_pend);
    chk("busy", busy_o, (m_q.size() != 0) || (m_pend != 0));
    chk("overflow", overflow_o, m_ovf);
    chk("timeout", timeout_o, m_to);
    chk("resp_valid", resp_valid_o, m_rv);
    chk("resp_data", resp_data_o, m_rd);
  endtask

  task automatic drive(input bit rv, input logic [ADDR_W-1:0] a, input bit rdy,
                       input bit rs, input logic [DATA_W-1:0] d, input bit clr);
    req_valid_i  = rv;
    req_paddr_i  = a;
    miss_ready_i = rdy;
    resp_valid_i = rs;
    resp_data_i  = d;
    clr_err_i    = clr;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, '0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    model_check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_check();
  endtask

  typedef struct {
    bit                rv;
    logic [ADDR_W-1:0] a;
    bit                rdy;
    bit                rs;
    bit                clr;
    bit                e_mv;
    logic [ADDR_W-1:0] e_pa;
    int                e_pend;
    bit                e_ovf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [LIN_W-1:0] l;

    // Queue, coalesce, overflow, clear, then drain under the MAX_OUT cap
    tbl[0]  = '{1, 40'h1000, 0, 0, 0, 1, 40'h1000, 0, 0};
    tbl[1]  = '{1, 40'h1010, 0, 0, 0, 1, 40'h1000, 0, 0};
    tbl[2]  = '{1, 40'h2000, 0, 0, 0, 1, 40'h1000, 0, 0};
    tbl[3]  = '{1, 40'h3000, 0, 0, 0, 1, 40'h1000, 0, 0};
    tbl[4]  = '{1, 40'h4000, 0, 0, 0, 1, 40'h1000, 0, 0};
    tbl[5]  = '{1, 40'h5000, 0, 0, 0, 1, 40'h1000, 0, 1};
    tbl[6]  = '{0, 40'h0,    0, 0, 1, 1, 40'h1000, 0, 0};
    tbl[7]  = '{0, 40'h0,    1, 0, 0, 1, 40'h2000, 1, 0};
    tbl[8]  = '{0, 40'h0,    1, 0, 0, 0, 40'h3000, 2, 0};
    tbl[9]  = '{0, 40'h0,    1, 0, 0, 0, 40'h3000, 2, 0};
    tbl[10] = '{0, 40'h0,    1, 1, 0, 1, 40'h3000, 1, 0};
    tbl[11] = '{0, 40'h0,    1, 0, 0, 0, 40'h4000, 2, 0};
    tbl[12] = '{0, 40'h0,    1, 1, 0, 1, 40'h4000, 1, 0};
    tbl[13] = '{0, 40'h0,    1, 1, 0, 0, 40'h0,    1, 0};
    tbl[14] = '{0, 40'h0,    1, 1, 0, 0, 40'h0,    0, 0};
    tbl[15] = '{0, 40'h0,    1, 1, 0, 0, 40'h0,    0, 0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rv, tbl[i].a, tbl[i].rdy, tbl[i].rs, 32'hD000_0000 + 32'(i), tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_mv", i), miss_valid_o, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_pa", i), miss_paddr_o, tbl[i].e_pa);
      chk($sformatf("tbl%0d_pend", i), pending_o, tbl[i].e_pend);
      chk($sformatf("tbl%0d_ovf", i), overflow_o, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_rv", i), resp_valid_o, tbl[i].rs);
      if (tbl[i].rs) chk($sformatf("tbl%0d_rd", i), resp_data_o, 32'hD000_0000 + 32'(i));
    end

    // Single miss round trip
    do_reset();
    drive(1, 40'h80_0000_1234, 1, 0, '0, 0);
    step();
    chk("rt_mv", miss_valid_o, 1'b1);
    chk("rt_pa", miss_paddr_o, 40'h80_0000_1200);
    drive(0, '0, 1, 0, '0, 0);
    step();
    chk("rt_pend1", pending_o, 3'd1);
    chk("rt_mv0", miss_valid_o, 1'b0);
    drive(0, '0, 1, 1, 32'hCAFE_F00D, 0);
    step();
    chk("rt_rv", resp_valid_o, 1'b1);
    chk("rt_rd", resp_data_o, 32'hCAFE_F00D);
    chk("rt_pend0", pending_o, 3'd0);
    chk("rt_busy", busy_o, 1'b0);
    drive(0, '0, 1, 0, 32'h1111_1111, 0);
    step();
    chk("rt_rv_off", resp_valid_o, 1'b0);
    chk("rt_rd_hold", resp_data_o, 32'hCAFE_F00D);

    // Watchdog: two in flight, a response restarts the count
    do_reset();
    drive(1, 40'h10_0000, 1, 0, '0, 0); step();
    drive(1, 40'h20_0000, 1, 0, '0, 0); step();
    drive(0, '0, 1, 0, '0, 0);          step();
    chk("to_pend2", pending_o, 3'd2);
    for (int k = 0; k < 9; k++) step();
    chk("to_early", timeout_o, 1'b0);
    drive(0, '0, 1, 1, 32'h5, 0); step();
    drive(0, '0, 1, 0, '0, 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("to_k%0d", k), timeout_o, k == 15);
    end
    drive(0, '0, 1, 0, '0, 1); step();
    chk("to_clr", timeout_o, 1'b0);
    drive(0, '0, 1, 1, 32'h6, 0); step(); step();
    chk("to_drain", pending_o, 3'd0);

    // Overflow set wins over a same-cycle clear
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, ADDR_W'(k + 1) << 12, 0, 0, '0, 0);
      step();
    end
    drive(1, 40'h9000, 0, 0, '0, 1); step();
    chk("ovf_setwins", overflow_o, 1'b1);
    drive(0, '0, 0, 0, '0, 1); step();
    chk("ovf_clr", overflow_o, 1'b0);

    // Asynchronous reset with traffic in flight, then a stray response
    do_reset();
    drive(1, 40'hA000, 1, 0, '0, 0); step();
    drive(1, 40'hB000, 1, 0, '0, 0); step();
    drive(1, 40'hC000, 1, 0, '0, 0); step();
    drive(1, 40'hD000, 0, 0, '0, 0); step();
    drive(1, 40'hE000, 0, 0, '0, 0); step();
    chk("ar_pend2", pending_o, 3'd2);
    drive(0, '0, 0, 0, '0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    model_check();
    chk("ar_paddr", miss_paddr_o, 40'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("ar_mv", miss_valid_o, 1'b0);
    chk("ar_busy", busy_o, 1'b0);
    drive(0, '0, 1, 1, 32'hBEEF, 0); step();
    chk("sp_rv", resp_valid_o, 1'b1);
    chk("sp_pend", pending_o, 3'd0);

    // Random traffic over a small line pool to exercise merging and limits
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      l = LIN_W'(32'h0123_4000 + $urandom_range(0, 7));
      drive($urandom_range(0, 1) == 1, {l, 6'($urandom_range(0, 63))},
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            $urandom, $urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
